// File: rtl/div_pkg.sv
// Shared FSM state type and quotient range limits for the DIV/IDIV sequencer.
// DIV_NEG_MIN_QUOT_EN widens the negative limits to accept -128 / -32768 quotients.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_WAIT,
        S_FIX,
        S_ERR
    } div_state_t;

    localparam int BYTE_QMAX = 127;
    localparam int WORD_QMAX = 32767;
    localparam int BYTE_UMAX = 255;

`ifdef DIV_NEG_MIN_QUOT_EN
    localparam int BYTE_QMIN = -128;
    localparam int WORD_QMIN = -32768;
`else
    localparam int BYTE_QMIN = -127;
    localparam int WORD_QMIN = -32767;
`endif

endpackage

// File: rtl/div_operand_prep.sv
// Operand extension, magnitude/sign extraction and early divide-error detection.
module div_operand_prep
    import div_pkg::*;
(
    input  logic        byte_op,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [31:0] dvd_mag,
    output logic [15:0] dvs_mag,
    output logic        dvd_neg,
    output logic        dvs_neg,
    output logic        zero_div,
    output logic        overflow
);

    logic [31:0] dvd_ext;
    logic [15:0] dvs_ext;
    logic [15:0] dvd_high;

    always_comb begin
        if (byte_op) begin
            dvd_ext = {{16{signed_op & dividend[15]}}, dividend[15:0]};
            dvs_ext = {{8{signed_op & divisor[7]}}, divisor[7:0]};
        end else begin
            dvd_ext = dividend;
            dvs_ext = divisor;
        end

        dvd_neg = signed_op & dvd_ext[31];
        dvs_neg = signed_op & dvs_ext[15];
        dvd_mag = dvd_neg ? (~dvd_ext + 32'd1) : dvd_ext;
        dvs_mag = dvs_neg ? (~dvs_ext + 16'd1) : dvs_ext;

        // High half >= divisor means the magnitude quotient cannot fit the result width.
        dvd_high = byte_op ? {8'h00, dvd_mag[15:8]} : dvd_mag[31:16];
        zero_div = (dvs_mag == '0);
        overflow = (dvd_high >= dvs_mag);
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/IDIV sequencer: prepares magnitudes, hands them to an unsigned divider over a
// toggle handshake, then fixes signs and range. Option macro: DIV_NEG_MIN_QUOT_EN.
module div_ctrl
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_op,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_err,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic [31:0] div_dividend,
    output logic [15:0] div_divisor,
    output logic        div_signed,
    output logic        div_run,
    input  logic        div_run_ack,
    input  logic [15:0] div_q,
    input  logic [15:0] div_r
);

    div_state_t state, state_nx;

    logic        byte_r, signed_r;
    logic [31:0] dvd_r;
    logic [15:0] dvs_r;
    logic [15:0] q_raw, r_raw;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic        dvd_neg, dvs_neg, zero_div, overflow;
    logic        run_match, q_neg, fix_err;
    logic [15:0] quot_nx, rem_nx;
    int          q_val;

    div_operand_prep u_prep (
        .byte_op   (byte_r),
        .signed_op (signed_r),
        .dividend  (dvd_r),
        .divisor   (dvs_r),
        .dvd_mag   (dvd_mag),
        .dvs_mag   (dvs_mag),
        .dvd_neg   (dvd_neg),
        .dvs_neg   (dvs_neg),
        .zero_div  (zero_div),
        .overflow  (overflow)
    );

    assign run_match    = (div_run == div_run_ack);
    assign busy         = (state != S_IDLE) || !run_match;
    assign div_signed   = 1'b0;
    assign div_dividend = dvd_mag;
    assign div_divisor  = dvs_mag;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && run_match) state_nx = S_PREP;
            S_PREP:  state_nx = (zero_div || overflow) ? S_ERR : S_WAIT;
            S_WAIT:  if (run_match) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        q_neg = dvd_neg ^ dvs_neg;
        q_val = int'({16'h0000, q_raw});
        if (q_neg) q_val = -q_val;

        if (byte_r)
            fix_err = signed_r ? ((q_val > BYTE_QMAX) || (q_val < BYTE_QMIN))
                               : (q_val > BYTE_UMAX);
        else
            fix_err = signed_r && ((q_val > WORD_QMAX) || (q_val < WORD_QMIN));

        quot_nx = q_neg   ? (~q_raw + 16'd1) : q_raw;
        rem_nx  = dvd_neg ? (~r_raw + 16'd1) : r_raw;
        if (byte_r) begin
            quot_nx[15:8] = '0;
            rem_nx[15:8]  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            div_err <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            div_run <= div_run_ack;
        end else begin
            done    <= 1'b0;
            div_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The divider has no reset, so a stale request is resynchronised first.
                    if (!run_match) begin
                        div_run <= div_run_ack;
                    end else if (start) begin
                        byte_r   <= byte_op;
                        signed_r <= signed_op;
                        dvd_r    <= dividend;
                        dvs_r    <= divisor;
                    end
                end
                S_PREP: if (!(zero_div || overflow)) div_run <= ~div_run;
                S_WAIT: begin
                    if (run_match) begin
                        q_raw <= div_q;
                        r_raw <= div_r;
                    end
                end
                S_FIX: begin
                    done    <= 1'b1;
                    div_err <= fix_err;
                    if (!fix_err) begin
                        quot <= quot_nx;
                        rem  <= rem_nx;
                    end
                end
                S_ERR: begin
                    done    <= 1'b1;
                    div_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
